// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the EX stage, owning architectural HI/LO.
// Runs MULT/MULTU/DIV/DIVU with a fixed latency (result computed at accept,
// held, and written at completion) and MTHI/MTLO in a single cycle.
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   start, md_op   qualified operation request (0..5 valid, 6/7 no-op)
//   rs_val, rt_val forwarded operands
//   busy           high while a MULT/DIV is in flight (registered)
//   hi, lo         architectural HI and LO registers
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]      hi_nxt, lo_nxt;
    logic [DW-1:0]      res_hi, res_hi_nxt, res_lo, res_lo_nxt;
    logic               res_wr, res_wr_nxt;

    // Arithmetic on the live operands; only sampled on an accepted op.
    logic               sgn;
    logic [2*DW-1:0]    a_ext, b_ext, product;
    logic               a_neg, b_neg;
    logic [DW-1:0]      a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

    assign sgn     = ~md_op[0];
    assign a_ext   = {{DW{sgn & rs_val[DW-1]}}, rs_val};
    assign b_ext   = {{DW{sgn & rt_val[DW-1]}}, rt_val};
    assign product = a_ext * b_ext;

    // Signed divide via magnitudes: truncation toward zero, remainder follows
    // the dividend, and 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign a_neg  = sgn & rs_val[DW-1];
    assign b_neg  = sgn & rt_val[DW-1];
    assign a_mag  = a_neg ? (~rs_val + DW'(1)) : rs_val;
    assign b_mag  = b_neg ? (~rt_val + DW'(1)) : rt_val;
    assign b_safe = (b_mag == '0) ? DW'(1) : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quo    = (a_neg ^ b_neg) ? (~q_mag + DW'(1)) : q_mag;
    assign rem    = a_neg ? (~r_mag + DW'(1)) : r_mag;

    // State and register update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_wr <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy   <= (state_nxt == ST_RUN);
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            res_hi <= res_hi_nxt;
            res_lo <= res_lo_nxt;
            res_wr <= res_wr_nxt;
        end
    end

    // Accept in idle, count down in run, commit held result on the last edge.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hi_nxt     = hi;
        lo_nxt     = lo;
        res_hi_nxt = res_hi;
        res_lo_nxt = res_lo;
        res_wr_nxt = res_wr;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            state_nxt  = ST_RUN;
                            cnt_nxt    = CNT_W'(MULT_CYCLES);
                            res_hi_nxt = product[2*DW-1:DW];
                            res_lo_nxt = product[DW-1:0];
                            res_wr_nxt = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_nxt  = ST_RUN;
                            cnt_nxt    = CNT_W'(DIV_CYCLES);
                            res_hi_nxt = rem;
                            res_lo_nxt = quo;
                            // Divide by zero still takes the full latency.
                            res_wr_nxt = (rt_val != '0);
                        end
                        OP_MTHI: hi_nxt = rs_val;
                        OP_MTLO: lo_nxt = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    if (res_wr) begin
                        hi_nxt = res_hi;
                        lo_nxt = res_lo;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
